// File: rtl/prog_loader.sv
// Byte-stream program loader: parses base/count/words/checksum and writes
// little-endian words to memory, holding the core in reset until a good load.
module prog_loader #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_vld,
  input  logic [7:0]  i_data,
  output logic        o_rdy,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic        o_core_rst_n,
  output logic        o_done,
  output logic        o_err
);

  localparam logic [2:0] S_ADDR  = 3'd0;
  localparam logic [2:0] S_CNT   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_CSUM  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  logic [2:0]  r_state;
  logic        r_live;
  logic [1:0]  r_bcnt;
  logic [31:0] r_waddr;
  logic [31:0] r_wdata;
  logic [15:0] r_cnt;
  logic [7:0]  r_csum;

  logic        w_rdy_state;
  logic        w_acc;
  logic [15:0] w_n;
  logic [32:0] w_end;

  // r_live keeps o_rdy low until the first clock edge after reset releases
  assign w_rdy_state = (r_state == S_ADDR) || (r_state == S_CNT) ||
                       (r_state == S_DATA) || (r_state == S_CSUM);
  assign o_rdy       = r_live & w_rdy_state;
  assign w_acc       = i_vld & o_rdy;
  assign w_n         = {i_data, r_cnt[7:0]};
  assign w_end       = {1'b0, r_waddr} + {15'd0, w_n, 2'b00};

  assign o_mem_we     = (r_state == S_WRITE);
  assign o_mem_addr   = r_waddr;
  assign o_mem_wdata  = r_wdata;
  assign o_done       = (r_state == S_DONE);
  assign o_err        = (r_state == S_ERR);
  assign o_core_rst_n = (r_state == S_DONE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_ADDR;
      r_live  <= 1'b0;
      r_bcnt  <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_csum  <= '0;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        S_ADDR: if (w_acc) begin
          r_waddr[{r_bcnt, 3'b000} +: 8] <= i_data;
          r_csum <= r_csum ^ i_data;
          r_bcnt <= r_bcnt + 2'd1;
          // byte 0 is already held, so its low bits decide alignment
          if (r_bcnt == 2'd3)
            r_state <= (r_waddr[1:0] != 2'b00) ? S_ERR : S_CNT;
        end
        S_CNT: if (w_acc) begin
          r_cnt[{r_bcnt[0], 3'b000} +: 8] <= i_data;
          r_csum <= r_csum ^ i_data;
          if (r_bcnt[0]) begin
            r_bcnt <= '0;
            if (w_end > 33'(MEM_BYTES))
              r_state <= S_ERR;
            else if (w_n == 16'd0)
              r_state <= S_CSUM;
            else
              r_state <= S_DATA;
          end else begin
            r_bcnt <= 2'd1;
          end
        end
        S_DATA: if (w_acc) begin
          r_wdata[{r_bcnt, 3'b000} +: 8] <= i_data;
          r_csum <= r_csum ^ i_data;
          r_bcnt <= r_bcnt + 2'd1;
          if (r_bcnt == 2'd3)
            r_state <= S_WRITE;
        end
        S_WRITE: begin
          // address advances on leaving WRITE so it is stable during the strobe
          r_waddr <= r_waddr + 32'd4;
          r_cnt   <= r_cnt - 16'd1;
          r_state <= (r_cnt == 16'd1) ? S_CSUM : S_DATA;
        end
        S_CSUM: if (w_acc) begin
          r_state <= (i_data == r_csum) ? S_DONE : S_ERR;
        end
        S_DONE:  r_state <= S_DONE;
        S_ERR:   r_state <= S_ERR;
        default: r_state <= S_ERR;
      endcase
    end
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter MEM_BYTES, default 1024, target memory size in bytes; SHALL be a power of two and a multiple of 4.
REQ-002 i_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 i_rst  input  1  reset, asynchronous, active-high.
REQ-004 i_vld  input  1  byte-stream valid.
REQ-005 i_data  input  8  byte-stream data.
REQ-006 o_rdy  output  1  loader can accept a byte; a byte is accepted in a cycle where i_vld=1 and o_rdy=1.
REQ-007 o_mem_we  output  1  word-write strobe to instruction/data memory.
REQ-008 o_mem_addr  output  32  byte address of the write, word aligned.
REQ-009 o_mem_wdata  output  32  write word, little-endian assembled.
REQ-010 o_core_rst_n  output  1  active-low reset to the pipeline; low until load succeeds.
REQ-011 o_done  output  1  load completed with a good checksum.
REQ-012 o_err  output  1  load aborted.

Function
REQ-013 Stream format, all fields little-endian: 4-byte base address, 2-byte word count N, N words of 4 bytes, 1-byte checksum.
REQ-014 Checksum SHALL be the XOR of every byte accepted before the checksum byte, header included.
REQ-015 FSM states SHALL be ADDR, CNT, DATA, WRITE, CSUM, DONE, ERR; the reset state is ADDR.
REQ-016 ADDR: accept 4 bytes; after the 4th byte, if base[1:0]!=0 -> ERR, else -> CNT.
REQ-017 CNT: accept 2 bytes; after the 2nd byte, if base+4*N > MEM_BYTES (33-bit compare, no wrap) -> ERR; else if N=0 -> CSUM; else -> DATA.
REQ-018 DATA: accept 4 bytes into o_mem_wdata, byte k to bits [8k+7:8k]; after the 4th byte -> WRITE.
REQ-019 WRITE: lasts exactly 1 cycle with o_mem_we=1 and o_rdy=0; the write address is base+4*i for word i (i from 0); the next state is DATA if words remain, else CSUM.
REQ-020 CSUM: accept 1 byte; if it equals the running XOR -> DONE, else -> ERR.
REQ-021 o_rdy SHALL be 1 in ADDR, CNT, DATA and CSUM, and 0 in WRITE, DONE and ERR.
REQ-022 The loader SHALL hold no skid buffer; a byte offered while o_rdy=0 SHALL NOT be consumed and SHALL NOT affect the checksum.
REQ-023 Gaps in i_vld SHALL stall the FSM with no state change.
REQ-024 DONE: o_done=1 and o_core_rst_n=1, held until i_rst.
REQ-025 ERR: o_err=1 and o_core_rst_n=0, held until i_rst; words already written are not rolled back.
REQ-026 o_mem_we SHALL never be asserted outside WRITE.
REQ-027 o_mem_addr and o_mem_wdata SHALL be stable while o_mem_we=1.
REQ-028 o_done and o_err SHALL never be asserted together.
REQ-029 Maximum memory-write throughput SHALL be 1 word per 5 cycles.

Reset
REQ-030 On i_rst=1, without waiting for a clock edge, the FSM SHALL go to ADDR and all outputs SHALL take these values: o_rdy=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_core_rst_n=0, o_done=0, o_err=0.
REQ-031 On i_rst=1, byte and word counters and the checksum SHALL be cleared.
REQ-032 o_rdy SHALL rise to 1 on the first rising i_clk edge after i_rst deasserts.
REQ-033 i_rst asserted mid-load SHALL abort the load; the next accepted byte is byte 0 of a new base address.

Verification
REQ-034 Stream 00 00 00 00 01 00 93 00 50 00 C2 -> one o_mem_we pulse with addr 0x00000000 and wdata 0x00500093, then o_done=1 and o_core_rst_n=1.
REQ-035 Stream 10 00 00 00 00 00 10 -> no o_mem_we pulses, o_done=1.
REQ-036 Base bytes 02 00 00 00 -> o_err=1 the cycle after the 4th byte, o_rdy=0, no writes, o_core_rst_n stays 0.
REQ-037 Base 0x3FC, N=2 -> o_err after the count bytes (0x3FC+8 > 1024), no writes.
REQ-038 Scenario of REQ-034 with checksum 0xC3 -> one write occurs, then o_err=1, o_done=0, o_core_rst_n=0.
REQ-039 i_vld held at 1 through WRITE, then i_rst pulsed during the 2nd data word -> the byte offered during WRITE is not consumed, all outputs go to reset values, and a following good stream loads correctly.
